div_clk_monitor: RTL and testbench
==================================

Name: div_clk_monitor

Overview:
- Receive-side checker for a divided clock generated from clk_in, e.g. the divide-by-4 output.
- Samples the divided clock in the clk_in domain and measures its period and high time in clk_in cycles.
- Declares lock after a run of consecutive correct periods. Flags ratio and duty errors, and flags a stuck divided clock.
- Sits next to the clock divider as a built-in self-check, with status feeding a status/CSR block.

Parameters:
- EXP_RATIO, 4, expected period of div_clk_in in clk_in cycles; even, ≥ 2.
- LOCK_COUNT, 8, consecutive good periods required to assert locked; ≥ 1.
- CNT_W, 8, width of the period/high/error counters; 2^CNT_W − 1 > 2*EXP_RATIO.

Ports:
- clk_in, input, 1, single clock; all logic on the rising edge.
- reset, input, 1, asynchronous active-high reset.
- div_clk_in, input, 1, divided clock under test, synchronous to clk_in.
- rise_pulse, output, 1, one-cycle pulse per detected rising edge of div_clk_in.
- period, output, CNT_W, last measured period in clk_in cycles.
- high_time, output, CNT_W, last measured high time in clk_in cycles.
- locked, output, 1, divided clock verified at EXP_RATIO with 50% duty.
- ratio_err, output, 1, one-cycle pulse on a bad period or high time.
- stuck_err, output, 1, one-cycle pulse when no rise is seen for 2*EXP_RATIO cycles.
- err_count, output, CNT_W, saturating count of ratio_err plus stuck_err events.

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0.
  - Internal sample regs d1 and d2 are 0.
  - cyc_cnt and hi_cnt are 0, good_cnt is 0, state is IDLE.
- Edge detection:
  - Each cycle d1 <= div_clk_in and d2 <= d1.
  - rise = d1 & ~d2; fall = ~d1 & d2.
  - All event outputs are registered. rise_pulse is high on the cycle after d1 first samples 1, i.e. 2 clk_in edges of latency from the input change.
- Counters, outside IDLE:
  - On rise: cyc_cnt <= 1, hi_cnt <= 1.
  - Otherwise cyc_cnt increments, saturating at all-ones.
  - hi_cnt increments while d1 is 1, saturating at all-ones.
  - On fall: high_time <= hi_cnt.
- State machine:
  - IDLE: wait for rise, then start the counters and go to MEASURE. No period is reported for the first rise.
  - MEASURE: on rise, period <= cyc_cnt. A period is good when cyc_cnt == EXP_RATIO and high_time == EXP_RATIO/2.
    - Good period: good_cnt++. When good_cnt reaches LOCK_COUNT, go to LOCKED and set locked = 1 on the same edge.
    - Bad period: ratio_err pulses, err_count++, good_cnt <= 0, stay in MEASURE.
  - LOCKED: on rise, a good period keeps the lock.
    - Bad period: ratio_err pulses, err_count++, locked <= 0 on that edge, good_cnt <= 0, go to MEASURE.
  - Timeout, in MEASURE or LOCKED: when cyc_cnt reaches 2*EXP_RATIO without a rise:
    - stuck_err pulses once, err_count++, locked <= 0, good_cnt <= 0.
    - Go to IDLE, and stay there until the next rise.
- Boundaries:
  - err_count saturates at all-ones; it never wraps.
  - good_cnt saturates at LOCK_COUNT.
  - A rise and a timeout cannot occur on the same edge. If they do, rise wins.
  - If no fall occurs within a period (constant high), high_time is stale and the period check still applies. A constant level always ends in timeout.
  - A reset assertion at any point clears lock and all counters immediately, with no pending pulses.
  - period and high_time hold their last values through errors and IDLE.

Test Plan:
1. Reset, then drive div_clk_in with pattern 0,0,1,1 repeating (EXP_RATIO=4):
   - rise_pulse every 4 cycles.
   - period=4 and high_time=2 after the second rise.
   - locked rises on the 9th rise (8 good periods after the first rise).
   - ratio_err never pulses, err_count=0.
2. While locked, insert one 5-cycle period (0,0,0,1,1):
   - ratio_err pulses once, period=5, err_count=1, locked drops on that rise.
   - locked returns after 8 further good periods.
3. Drive a duty-error pattern 0,1,1,1 with period 4:
   - high_time=3, ratio_err on every rise, locked stays 0, err_count increments every period.
4. While locked, hold div_clk_in at 0:
   - stuck_err pulses once, 8 cycles after the last rise.
   - locked=0, err_count+1, no further pulses while held.
   - Resuming the pattern relocks after 9 rises.
5. Assert reset mid-lock:
   - All outputs are 0 asynchronously.
   - After release, behaviour matches scenario 1 from the start.
6. Force 300 error periods with CNT_W=8:
   - err_count saturates at 255 and does not wrap.

Source files
------------

// File: rtl/div_clk_monitor.sv
`default_nettype none
// ============================================================================
// Module   : div_clk_monitor
// Brief    : Receive-side checker for a divided clock; measures period and
//            high time in clk_in cycles, declares lock, flags ratio/duty/stuck.
// Revision : 1.0 - initial release
// ============================================================================
module div_clk_monitor #(
    parameter int EXP_RATIO  = 4,
    parameter int LOCK_COUNT = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             div_clk_in,
    output logic             rise_pulse,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             locked,
    output logic             ratio_err,
    output logic             stuck_err,
    output logic [CNT_W-1:0] err_count
);

    localparam int               GOOD_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] c_EXP     = CNT_W'(EXP_RATIO);
    localparam logic [CNT_W-1:0] c_HALF    = CNT_W'(EXP_RATIO / 2);
    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(2 * EXP_RATIO);
    localparam logic [CNT_W-1:0] c_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);
    localparam logic [GOOD_W-1:0] c_LOCK   = GOOD_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               d1_q, d1_d;
    logic               d2_q, d2_d;
    logic [CNT_W-1:0]   cyc_cnt_q, cyc_cnt_d;
    logic [CNT_W-1:0]   hi_cnt_q, hi_cnt_d;
    logic [GOOD_W-1:0]  good_cnt_q, good_cnt_d;
    logic               rise_pulse_q, rise_pulse_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   high_time_q, high_time_d;
    logic               locked_q, locked_d;
    logic               ratio_err_q, ratio_err_d;
    logic               stuck_err_q, stuck_err_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;

    logic               w_rise;
    logic               w_fall;
    logic               w_good_period;
    logic               w_err_inc;
    logic [GOOD_W-1:0]  w_good_next;

    always_comb begin
        w_rise        = d1_q & ~d2_q;
        w_fall        = ~d1_q & d2_q;
        // high_time_q is the duty of the period now closing; rise and fall never coincide
        w_good_period = (cyc_cnt_q == c_EXP) && (high_time_q == c_HALF);
        w_good_next   = (good_cnt_q == c_LOCK) ? c_LOCK : good_cnt_q + GOOD_W'(1);
        w_err_inc     = 1'b0;

        state_d      = state_q;
        d1_d         = div_clk_in;
        d2_d         = d1_q;
        cyc_cnt_d    = cyc_cnt_q;
        hi_cnt_d     = hi_cnt_q;
        good_cnt_d   = good_cnt_q;
        rise_pulse_d = w_rise;
        period_d     = period_q;
        high_time_d  = high_time_q;
        locked_d     = locked_q;
        ratio_err_d  = 1'b0;
        stuck_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_rise) begin
                    cyc_cnt_d = c_ONE;
                    hi_cnt_d  = c_ONE;
                    state_d   = ST_MEASURE;
                end
            end
            default: begin
                if (w_rise) begin
                    cyc_cnt_d = c_ONE;
                    hi_cnt_d  = c_ONE;
                end else begin
                    if (cyc_cnt_q != c_MAX) cyc_cnt_d = cyc_cnt_q + c_ONE;
                    if (d1_q && (hi_cnt_q != c_MAX)) hi_cnt_d = hi_cnt_q + c_ONE;
                end

                if (w_fall) high_time_d = hi_cnt_q;

                if (w_rise) begin
                    period_d = cyc_cnt_q;
                    if (w_good_period) begin
                        good_cnt_d = w_good_next;
                        if (w_good_next == c_LOCK) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        ratio_err_d = 1'b1;
                        w_err_inc   = 1'b1;
                        good_cnt_d  = '0;
                        locked_d    = 1'b0;
                        state_d     = ST_MEASURE;
                    end
                end else if (cyc_cnt_q == c_TIMEOUT) begin
                    // Divided clock stopped: park in IDLE until it toggles again
                    stuck_err_d = 1'b1;
                    w_err_inc   = 1'b1;
                    good_cnt_d  = '0;
                    locked_d    = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
        endcase

        err_count_d = (w_err_inc && (err_count_q != c_MAX)) ? err_count_q + c_ONE
                                                            : err_count_q;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            d1_q         <= 1'b0;
            d2_q         <= 1'b0;
            cyc_cnt_q    <= '0;
            hi_cnt_q     <= '0;
            good_cnt_q   <= '0;
            rise_pulse_q <= 1'b0;
            period_q     <= '0;
            high_time_q  <= '0;
            locked_q     <= 1'b0;
            ratio_err_q  <= 1'b0;
            stuck_err_q  <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            d1_q         <= d1_d;
            d2_q         <= d2_d;
            cyc_cnt_q    <= cyc_cnt_d;
            hi_cnt_q     <= hi_cnt_d;
            good_cnt_q   <= good_cnt_d;
            rise_pulse_q <= rise_pulse_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            locked_q     <= locked_d;
            ratio_err_q  <= ratio_err_d;
            stuck_err_q  <= stuck_err_d;
            err_count_q  <= err_count_d;
        end
    end

    assign rise_pulse = rise_pulse_q;
    assign period     = period_q;
    assign high_time  = high_time_q;
    assign locked     = locked_q;
    assign ratio_err  = ratio_err_q;
    assign stuck_err  = stuck_err_q;
    assign err_count  = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_div_clk_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_clk_monitor
// Brief    : Directed bench for div_clk_monitor with an event-level reference
//            model compared every cycle plus literal anchor checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_clk_monitor;

    localparam int EXP_RATIO  = 4;
    localparam int LOCK_COUNT = 8;
    localparam int CNT_W      = 8;
    localparam int ERR_MAX    = (1 << CNT_W) - 1;

    logic             clk_in = 1'b0;
    logic             reset;
    logic             div_clk_in;
    logic             rise_pulse;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             locked;
    logic             ratio_err;
    logic             stuck_err;
    logic [CNT_W-1:0] err_count;

    div_clk_monitor #(
        .EXP_RATIO  (EXP_RATIO),
        .LOCK_COUNT (LOCK_COUNT),
        .CNT_W      (CNT_W)
    ) u_dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .div_clk_in (div_clk_in),
        .rise_pulse (rise_pulse),
        .period     (period),
        .high_time  (high_time),
        .locked     (locked),
        .ratio_err  (ratio_err),
        .stuck_err  (stuck_err),
        .err_count  (err_count)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;
    int n_cyc   = 0;

    // Reference model: timestamps of input samples, not register images
    bit s1, s2;
    int now, last_rise, streak;
    bit armed;
    bit m_rise, m_locked, m_ratio, m_stuck;
    int m_period, m_high, m_err;

    task automatic model_reset();
        s1 = 0; s2 = 0; now = 0; last_rise = 0; streak = 0; armed = 0;
        m_rise = 0; m_locked = 0; m_ratio = 0; m_stuck = 0;
        m_period = 0; m_high = 0; m_err = 0;
    endtask

    task automatic model_step(input bit v);
        bit rise, fall;
        int idx, span;
        rise = s1 && !s2;
        fall = !s1 && s2;
        idx  = now - 1;
        span = idx - last_rise;
        m_rise = rise; m_ratio = 0; m_stuck = 0;
        if (!armed) begin
            if (rise) begin
                armed = 1;
                last_rise = idx;
            end
        end else if (rise) begin
            m_period = span;
            if (span == EXP_RATIO && m_high == EXP_RATIO / 2) begin
                if (streak < LOCK_COUNT) streak++;
            end else begin
                m_ratio = 1;
                streak = 0;
                if (m_err < ERR_MAX) m_err++;
            end
            m_locked = (streak == LOCK_COUNT);
            last_rise = idx;
        end else begin
            if (fall) m_high = span;
            if (span == 2 * EXP_RATIO) begin
                m_stuck = 1; streak = 0; m_locked = 0; armed = 0;
                if (m_err < ERR_MAX) m_err++;
            end
        end
        s2 = s1; s1 = v; now++;
    endtask

    task automatic compare();
        n_tests++;
        if (rise_pulse !== m_rise || period !== CNT_W'(m_period) ||
            high_time !== CNT_W'(m_high) || locked !== m_locked ||
            ratio_err !== m_ratio || stuck_err !== m_stuck ||
            err_count !== CNT_W'(m_err)) begin
            n_fail++;
            $display("FAIL cycle%0d model: got rp=%b per=%0d hi=%0d lk=%b re=%b se=%b ec=%0d, want rp=%b per=%0d hi=%0d lk=%b re=%b se=%b ec=%0d",
                     n_cyc, rise_pulse, period, high_time, locked, ratio_err, stuck_err, err_count,
                     m_rise, m_period, m_high, m_locked, m_ratio, m_stuck, m_err);
        end
    endtask

    task automatic check_lit(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // One clk_in cycle: drive, advance model on the edge, compare mid-cycle
    task automatic tick(input bit v);
        div_clk_in = v;
        @(posedge clk_in);
        if (reset) model_reset();
        else model_step(v);
        @(negedge clk_in);
        n_cyc++;
        compare();
    endtask

    function automatic bit pat_good(input int i);
        return (i % 4) >= 2;
    endfunction

    function automatic bit pat_duty(input int i);
        return (i % 4) != 0;
    endfunction

    task automatic check_all_zero(input string tag);
        check_lit({tag, "_rise_pulse"}, int'(rise_pulse), 0);
        check_lit({tag, "_period"},     int'(period), 0);
        check_lit({tag, "_high_time"},  int'(high_time), 0);
        check_lit({tag, "_locked"},     int'(locked), 0);
        check_lit({tag, "_ratio_err"},  int'(ratio_err), 0);
        check_lit({tag, "_stuck_err"},  int'(stuck_err), 0);
        check_lit({tag, "_err_count"},  int'(err_count), 0);
    endtask

    // Lock sequence from a clean start: lock lands on the 9th rise
    task automatic run_lock_from_reset(input string tag);
        for (int i = 0; i < 36; i++) begin
            tick(pat_good(i));
            if (i == 7) begin
                check_lit({tag, "_period_2nd_rise"}, int'(period), 4);
                check_lit({tag, "_high_2nd_rise"}, int'(high_time), 2);
            end
            if (i == 34) check_lit({tag, "_locked_before_9th"}, int'(locked), 0);
            if (i == 35) check_lit({tag, "_locked_at_9th"}, int'(locked), 1);
        end
        check_lit({tag, "_err_count"}, int'(err_count), 0);
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all_zero("async_reset");
        tick(1'b0);
        tick(1'b0);
        reset = 1'b0;
    endtask

    initial begin
        int stuck_seen;
        int base_err;
        bit ins[5];
        ins[0] = 0; ins[1] = 0; ins[2] = 0; ins[3] = 1; ins[4] = 1;

        reset = 1'b1;
        div_clk_in = 1'b0;
        model_reset();
        @(negedge clk_in);
        tick(1'b0);
        tick(1'b0);
        check_all_zero("reset");
        reset = 1'b0;

        // Clean divide-by-4 reaches lock
        run_lock_from_reset("s1");
        for (int i = 0; i < 8; i++) tick(pat_good(i));

        // One long period while locked
        for (int i = 0; i < 5; i++) tick(ins[i]);
        check_lit("s2_ratio_err", int'(ratio_err), 1);
        check_lit("s2_period", int'(period), 5);
        check_lit("s2_err_count", int'(err_count), 1);
        check_lit("s2_locked_drop", int'(locked), 0);
        for (int i = 0; i < 32; i++) begin
            tick(pat_good(i));
            if (i == 27) check_lit("s2_relock_early", int'(locked), 0);
            if (i == 31) check_lit("s2_relock", int'(locked), 1);
        end

        // Divided clock stuck low while locked
        stuck_seen = 0;
        base_err = int'(err_count);
        for (int i = 0; i < 20; i++) begin
            tick(1'b0);
            if (stuck_err) stuck_seen++;
            if (i == 6) check_lit("s4_no_stuck_yet", int'(stuck_err), 0);
            if (i == 7) check_lit("s4_stuck_at_8", int'(stuck_err), 1);
        end
        check_lit("s4_stuck_once", stuck_seen, 1);
        check_lit("s4_err_count", int'(err_count), base_err + 1);
        check_lit("s4_locked", int'(locked), 0);
        for (int i = 0; i < 36; i++) begin
            tick(pat_good(i));
            if (i == 34) check_lit("s4_relock_early", int'(locked), 0);
            if (i == 35) check_lit("s4_relock", int'(locked), 1);
        end

        // Reset while locked, then behave as from power-up
        async_reset();
        run_lock_from_reset("s5");

        // Duty error 0,1,1,1
        async_reset();
        for (int i = 0; i < 40; i++) tick(pat_duty(i));
        check_lit("s3_high_time", int'(high_time), 3);
        check_lit("s3_locked", int'(locked), 0);
        check_lit("s3_err_count", int'(err_count), 9);

        // Continue to 300 error periods: counter pins at all-ones
        for (int i = 40; i < 1200; i++) tick(pat_duty(i));
        check_lit("s6_err_sat", int'(err_count), ERR_MAX);
        for (int i = 0; i < 8; i++) tick(pat_duty(i));
        check_lit("s6_err_no_wrap", int'(err_count), ERR_MAX);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
